// File: rtl/text_render_pkg.sv
// Shared defaults and screen-word layout for the text-mode renderer.
// A screen word is {bg, fg, char}, with char in the low bits.
package text_render_pkg;

    localparam int DEF_COLOR_BITS            = 4;
    localparam int DEF_HORIZONTAL_SLOT_COUNT = 80;
    localparam int DEF_VERTICAL_SLOT_COUNT   = 60;
    localparam int DEF_PIXEL_DIM_WIDTH       = 10;
    localparam int DEF_SCREEN_ADDRESS_WIDTH  = 13;
    localparam int DEF_CHAR_BITS             = 7;
    localparam int DEF_GLYPH_W_LOG2          = 3;
    localparam int DEF_GLYPH_H_LOG2          = 3;
    localparam int DEF_BLINK_FRAMES          = 30;

    localparam int CHAR_LSB = 0;

    function automatic int fg_lsb(input int char_bits);
        return CHAR_LSB + char_bits;
    endfunction

    function automatic int bg_lsb(input int char_bits, input int color_bits);
        return CHAR_LSB + char_bits + color_bits;
    endfunction

    localparam int FG_LSB = fg_lsb(DEF_CHAR_BITS);
    localparam int BG_LSB = bg_lsb(DEF_CHAR_BITS, DEF_COLOR_BITS);

    typedef enum logic {
        CURSOR_BLOCK     = 1'b0,
        CURSOR_UNDERLINE = 1'b1
    } cursor_mode_e;

endpackage

// File: rtl/text_blink_timer.sv
// Cursor blink phase: blink_on toggles once every BLINK_FRAMES frame ticks.
module text_blink_timer
    import text_render_pkg::*;
#(
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic clk,
    input  logic resetn,
    input  logic frame_tick,
    output logic blink_on
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] count;

    // Reset deliberately takes priority over a coincident frame_tick.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count    <= '0;
            blink_on <= 1'b1;
        end else if (frame_tick) begin
            if (count == CW'(BLINK_FRAMES - 1)) begin
                count    <= '0;
                blink_on <= ~blink_on;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/text_render_pipe.sv
// Three-stage text-mode pixel renderer: slot lookup, screen BRAM, glyph BRAM,
// then attribute/cursor colour selection into a registered output.
module text_render_pipe
    import text_render_pkg::*;
#(
    parameter int COLOR_BITS            = DEF_COLOR_BITS,
    parameter int HORIZONTAL_SLOT_COUNT = DEF_HORIZONTAL_SLOT_COUNT,
    parameter int VERTICAL_SLOT_COUNT   = DEF_VERTICAL_SLOT_COUNT,
    parameter int PIXEL_DIM_WIDTH       = DEF_PIXEL_DIM_WIDTH,
    parameter int SCREEN_ADDRESS_WIDTH  = DEF_SCREEN_ADDRESS_WIDTH,
    parameter int CHAR_BITS             = DEF_CHAR_BITS,
    parameter int GLYPH_W_LOG2          = DEF_GLYPH_W_LOG2,
    parameter int GLYPH_H_LOG2          = DEF_GLYPH_H_LOG2,
    parameter int BLINK_FRAMES          = DEF_BLINK_FRAMES
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   px_valid,
    input  logic [PIXEL_DIM_WIDTH-1:0]             px_x,
    input  logic [PIXEL_DIM_WIDTH-1:0]             px_y,
    output logic                                   px_out_valid,
    output logic [COLOR_BITS-1:0]                  px_color,
    input  logic                                   frame_tick,
    input  logic                                   cursor_en,
    input  logic                                   cursor_mode,
    input  logic [PIXEL_DIM_WIDTH-GLYPH_W_LOG2-1:0] cursor_x,
    input  logic [PIXEL_DIM_WIDTH-GLYPH_H_LOG2-1:0] cursor_y,
    output logic [SCREEN_ADDRESS_WIDTH-1:0]        screen_addr,
    input  logic [2*COLOR_BITS+CHAR_BITS-1:0]      screen_data,
    output logic                                   screen_ren,
    output logic [CHAR_BITS+GLYPH_W_LOG2-1:0]      tex_addr,
    input  logic [2**GLYPH_H_LOG2-1:0]             tex_data,
    output logic                                   tex_ren
);

    localparam int SX_W  = PIXEL_DIM_WIDTH - GLYPH_W_LOG2;
    localparam int SY_W  = PIXEL_DIM_WIDTH - GLYPH_H_LOG2;
    localparam int FG_LO = fg_lsb(CHAR_BITS);
    localparam int BG_LO = bg_lsb(CHAR_BITS, COLOR_BITS);

    logic                    blink_on;
    logic [SX_W-1:0]         sx;
    logic [SY_W-1:0]         sy;
    logic                    in_range_0;
    logic                    is_cursor_0;

    logic                    valid_1, in_range_1, is_cursor_1, mode_1;
    logic [GLYPH_W_LOG2-1:0] col_1;
    logic [GLYPH_H_LOG2-1:0] row_1;

    logic                    valid_2, in_range_2, is_cursor_2, mode_2;
    logic [GLYPH_H_LOG2-1:0] row_2;
    logic [COLOR_BITS-1:0]   fg_2, bg_2;

    logic                    glyph_bit, invert;

    text_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk       (clk),
        .resetn    (resetn),
        .frame_tick(frame_tick),
        .blink_on  (blink_on)
    );

    assign sx          = px_x[PIXEL_DIM_WIDTH-1:GLYPH_W_LOG2];
    assign sy          = px_y[PIXEL_DIM_WIDTH-1:GLYPH_H_LOG2];
    assign in_range_0  = (32'(sx) < HORIZONTAL_SLOT_COUNT) && (32'(sy) < VERTICAL_SLOT_COUNT);
    assign is_cursor_0 = cursor_en && (sx == cursor_x) && (sy == cursor_y);
    assign screen_addr = SCREEN_ADDRESS_WIDTH'(32'(sy) * 32'(HORIZONTAL_SLOT_COUNT) + 32'(sx));
    assign screen_ren  = px_valid & in_range_0 & resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_1 <= 1'b0;
        end else begin
            valid_1     <= px_valid;
            in_range_1  <= in_range_0;
            col_1       <= px_x[GLYPH_W_LOG2-1:0];
            row_1       <= px_y[GLYPH_H_LOG2-1:0];
            is_cursor_1 <= is_cursor_0;
            mode_1      <= cursor_mode;
        end
    end

    assign tex_addr = {screen_data[CHAR_LSB +: CHAR_BITS], col_1};
    assign tex_ren  = valid_1 & in_range_1 & resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_2 <= 1'b0;
        end else begin
            valid_2     <= valid_1;
            in_range_2  <= in_range_1;
            row_2       <= row_1;
            fg_2        <= screen_data[FG_LO +: COLOR_BITS];
            bg_2        <= screen_data[BG_LO +: COLOR_BITS];
            is_cursor_2 <= is_cursor_1;
            mode_2      <= mode_1;
        end
    end

    // Underline cursor only inverts the bottom glyph row.
    assign glyph_bit = tex_data[row_2];
    assign invert    = is_cursor_2 & blink_on & ((mode_2 == CURSOR_BLOCK) | (&row_2));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            px_out_valid <= 1'b0;
            px_color     <= '0;
        end else begin
            px_out_valid <= valid_2;
            if (!in_range_2)
                px_color <= '0;
            else
                px_color <= (glyph_bit ^ invert) ? fg_2 : bg_2;
        end
    end

endmodule

// File: tb/tb_text_render_pipe.sv
// Scoreboard bench for text_render_pipe with behavioural screen/glyph BRAMs.
module tb_text_render_pipe;

    logic        clk = 1'b0;
    logic        resetn;
    logic        px_valid;
    logic [9:0]  px_x, px_y;
    logic        px_out_valid;
    logic [3:0]  px_color;
    logic        frame_tick;
    logic        cursor_en;
    logic        cursor_mode;
    logic [6:0]  cursor_x, cursor_y;
    logic [12:0] screen_addr;
    logic [14:0] screen_data;
    logic        screen_ren;
    logic [9:0]  tex_addr;
    logic [7:0]  tex_data;
    logic        tex_ren;

    text_render_pipe dut (
        .clk         (clk),
        .resetn      (resetn),
        .px_valid    (px_valid),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_out_valid(px_out_valid),
        .px_color    (px_color),
        .frame_tick  (frame_tick),
        .cursor_en   (cursor_en),
        .cursor_mode (cursor_mode),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .screen_addr (screen_addr),
        .screen_data (screen_data),
        .screen_ren  (screen_ren),
        .tex_addr    (tex_addr),
        .tex_data    (tex_data),
        .tex_ren     (tex_ren)
    );

    always #5 clk = ~clk;

    logic [14:0] screen_mem [0:8191];
    logic [7:0]  tex_mem [0:1023];

    always @(posedge clk) begin
        if (screen_ren) screen_data <= screen_mem[screen_addr];
        if (tex_ren)    tex_data    <= tex_mem[tex_addr];
    end

    typedef struct {
        logic [3:0] color;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_pushed = 0;
    int   n_out = 0;
    int   blink_cnt = 0;
    bit   blink_on_m = 1'b1;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Reference colour computed straight from memory contents and cursor state.
    function automatic logic [3:0] expColor(input int x, input int y);
        int         sx, sy, row, col;
        logic [14:0] w;
        logic [7:0]  glyph;
        logic        b, cur, inv;
        sx = x >> 3;
        sy = y >> 3;
        if (!(sx < 80 && sy < 60)) return 4'h0;
        row   = y % 8;
        col   = x % 8;
        w     = screen_mem[sy * 80 + sx];
        glyph = tex_mem[{w[6:0], 3'(col)}];
        b     = glyph[row];
        cur   = cursor_en && (sx == int'(cursor_x)) && (sy == int'(cursor_y));
        inv   = cur && blink_on_m && (cursor_mode == 1'b0 || row == 7);
        return (b ^ inv) ? w[10:7] : w[14:11];
    endfunction

    always @(negedge clk) begin
        if (resetn && px_out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("stale_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("px_color", 32'(px_color), 32'(e.color));
                checkOutput("latency", 32'(cyc), 32'(e.due));
                n_out++;
            end
        end
    end

    task automatic applyStimulus(input int x, input int y);
        exp_t e;
        @(negedge clk);
        px_valid = 1'b1;
        px_x     = 10'(x);
        px_y     = 10'(y);
        e.color  = expColor(x, y);
        e.due    = cyc + 3;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            px_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic applyFrameTicks(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_tick = 1'b1;
            if (blink_cnt == 29) begin
                blink_cnt  = 0;
                blink_on_m = !blink_on_m;
            end else begin
                blink_cnt++;
            end
        end
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetn      = 1'b0;
        px_valid    = 1'b0;
        px_x        = '0;
        px_y        = '0;
        frame_tick  = 1'b0;
        cursor_en   = 1'b0;
        cursor_mode = 1'b0;
        cursor_x    = '0;
        cursor_y    = '0;
        for (int i = 0; i < 8192; i++) screen_mem[i] = 15'($urandom);
        for (int i = 0; i < 1024; i++) tex_mem[i] = 8'($urandom);
        screen_mem[82]     = {4'h1, 4'hE, 7'h41};
        tex_mem[10'h209]   = 8'b0000_0010;

        // Reset: outputs cleared and BRAM enables held off
        repeat (3) @(negedge clk);
        px_valid = 1'b1;
        px_x     = 10'd17;
        px_y     = 10'd9;
        #1;
        checkOutput("reset_screen_ren", 32'(screen_ren), 32'd0);
        checkOutput("reset_out_valid", 32'(px_out_valid), 32'd0);
        checkOutput("reset_color", 32'(px_color), 32'd0);
        @(posedge clk); #1;
        checkOutput("reset_tex_ren", 32'(tex_ren), 32'd0);
        @(negedge clk);
        px_valid = 1'b0;
        resetn   = 1'b1;
        idle(2);

        // Basic lookup
        applyStimulus(17, 9);
        #1;
        checkOutput("screen_addr", 32'(screen_addr), 32'd82);
        checkOutput("screen_ren", 32'(screen_ren), 32'd1);
        @(posedge clk); #1;
        checkOutput("tex_addr", 32'(tex_addr), 32'h209);
        checkOutput("tex_ren", 32'(tex_ren), 32'd1);
        idle(1);
        waitDrain();
        tex_mem[10'h209] = 8'h00;
        applyStimulus(17, 9);
        idle(1);
        waitDrain();
        tex_mem[10'h209] = 8'b0000_0010;

        // Out of range
        applyStimulus(640, 0);
        #1;
        checkOutput("oor_screen_ren", 32'(screen_ren), 32'd0);
        @(posedge clk); #1;
        checkOutput("oor_tex_ren", 32'(tex_ren), 32'd0);
        idle(1);
        waitDrain();

        // Block cursor across blink phases
        cursor_en   = 1'b1;
        cursor_mode = 1'b0;
        cursor_x    = 7'd2;
        cursor_y    = 7'd1;
        applyStimulus(17, 9); idle(1); waitDrain();
        applyFrameTicks(30);
        applyStimulus(17, 9); idle(1); waitDrain();
        applyFrameTicks(30);
        applyStimulus(17, 9); idle(1); waitDrain();

        // Underline cursor
        cursor_mode = 1'b1;
        tex_mem[{7'h41, 3'd0}] = 8'h00;
        applyStimulus(16, 15);
        applyStimulus(16, 14);
        idle(1);
        waitDrain();

        // Streaming a full text row
        cursor_mode = 1'b0;
        cursor_x    = 7'd10;
        cursor_y    = 7'd5;
        for (int i = 400; i < 480; i++) screen_mem[i] = 15'($urandom);
        for (int i = 0; i < 80; i++) applyStimulus(i * 8 + int'($urandom_range(0, 7)), 40 + int'($urandom_range(0, 7)));
        idle(1);
        waitDrain();

        // Reset mid-stream with a coincident frame tick
        cursor_x = 7'd2;
        cursor_y = 7'd1;
        applyFrameTicks(10);
        applyStimulus(17, 9);
        applyStimulus(18, 9);
        @(negedge clk);
        px_valid   = 1'b1;
        px_x       = 10'd5;
        px_y       = 10'd3;
        resetn     = 1'b0;
        frame_tick = 1'b1;
        n_pushed  -= sb.size();
        sb.delete();
        blink_cnt  = 0;
        blink_on_m = 1'b1;
        #1;
        checkOutput("rst_screen_ren", 32'(screen_ren), 32'd0);
        checkOutput("rst_tex_ren", 32'(tex_ren), 32'd0);
        @(negedge clk);
        resetn     = 1'b1;
        frame_tick = 1'b0;
        px_valid   = 1'b0;
        checkOutput("rst_out_valid", 32'(px_out_valid), 32'd0);
        checkOutput("rst_color", 32'(px_color), 32'd0);
        idle(6);
        applyFrameTicks(29);
        applyStimulus(17, 9); idle(1); waitDrain();
        applyFrameTicks(1);
        applyStimulus(17, 9); idle(1); waitDrain();

        checkOutput("output_count", 32'(n_out), 32'(n_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
